multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the MIPS core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB, and shares one variable-latency memory port between instruction fetch and load/store. It consumes the decoder's `mem_cmd`, `reg_wen` and `pc_src` fields and drives the write enables, mux selects and memory handshake of the datapath.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of cycles without ack that a memory request may wait before the block enters FAULT.
- `W_RET`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_cmd`  in  `W_MEM_CMD`  from the decoder: `MEM_NOP`, `MEM_READ` or `MEM_WRITE`.
- `reg_wen`  in  1  from the decoder: `WREN` or `WDIS`.
- `pc_src`  in  `W_PC_SRC`  from the decoder: `PC_SRC_NEXT`, `PC_SRC_BRCH` or `PC_SRC_JUMP`.
- `br_cond`  in  1  branch condition met; computed by the datapath and valid in EXEC.
- `halt_req`  in  1  syscall exit detected; valid in DECODE.
- `mem_ack`  in  1  memory completion strobe.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write; valid only while `mem_req`=1.
- `addr_sel`  out  1  address mux select: 0 = PC, 1 = latched ALU result.
- `ir_we`  out  1  latch the instruction register and the MDR.
- `alu_we`  out  1  latch the ALU result register.
- `rf_we`  out  1  register-file write enable.
- `pc_we`  out  1  PC write enable.
- `pc_sel`  out  `W_PC_SRC`  PC next-value mux select.
- `halted`  out  1  sticky halt flag.
- `fault`  out  1  sticky memory-timeout flag.
- `retired`  out  `W_RET`  count of retired instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- Outputs are Moore-style, decoded from the state register.
- `mem_cmd`, `reg_wen` and `pc_src` are sampled in every state after DECODE; the datapath holds the IR stable across the instruction.
- **FETCH:** `mem_req`=1, `addr_sel`=0, `mem_we`=0.
  - On `mem_ack`: `ir_we`=1 in that same cycle, then go to DECODE.
- **DECODE:** one cycle, register-file read.
  - If `halt_req`: go to HALT. The syscall does not increment `retired`.
  - Otherwise go to EXEC.
- **EXEC:** one cycle, `alu_we`=1.
  - If `mem_cmd`≠`MEM_NOP`: go to MEM.
  - Otherwise go to WB.
- **MEM:** `mem_req`=1, `addr_sel`=1, `mem_we`=(`mem_cmd`==`MEM_WRITE`).
  - On `mem_ack`: `ir_we`=1 only for `MEM_READ` (latches the MDR), then go to WB.
- **WB:** one cycle.
  - `rf_we`=(`reg_wen`==`WREN`) and (`mem_cmd`≠`MEM_WRITE`).
  - `pc_we`=1.
  - `pc_sel`: `PC_SRC_BRCH` when `pc_src`==`PC_SRC_BRCH` and `br_cond`=1; `PC_SRC_NEXT` when `pc_src`==`PC_SRC_BRCH` and `br_cond`=0; otherwise `pc_src` unchanged.
  - `retired` increments by 1 and wraps modulo 2^`W_RET`.
  - Next state: FETCH.
- **`br_cond` capture:** `br_cond` is registered at the end of EXEC so that WB uses the EXEC-time value.
- **HALT:** all strobes 0, `halted`=1. Leaves only via reset.
- **FAULT:** all strobes 0, `fault`=1. Leaves only via reset.
- **Timeout counter:**
  - Clears on entry to FETCH or MEM.
  - Increments each cycle that `mem_req`=1 and `mem_ack`=0.
  - When it reaches `MEM_TIMEOUT` with no ack, the next state is FAULT.
  - An ack arriving in the same cycle the count reaches `MEM_TIMEOUT` wins: the request completes normally.
- **Stray ack:** `mem_ack` outside FETCH or MEM is ignored.
- **Reset values:** state=FETCH, counter=0, `retired`=0, `halted`=0, `fault`=0, registered `br_cond`=0. After reset, `mem_req`=1 is the FETCH Moore output.
- **Reset mid-request:** reset asserted during a memory request resets the request state immediately; in-flight memory transactions are abandoned. The memory must accept a new request after reset without requiring a prior ack.

## Timing
- Zero-wait memory (ack in the first request cycle):
  - ALU, branch and jump instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW and SW: 5 cycles.
- Each ack wait cycle adds 1 cycle to the instruction.
- Handshake:
  - `mem_req` rises on entry to FETCH or MEM and stays high until the cycle in which `mem_ack` is sampled high.
  - `mem_req` is low in the cycle after that ack.
- `pc_we` and `rf_we` are asserted only in WB, for exactly one cycle each per instruction.

## Structure
- State encodings (3-bit localparams) go in the shared header `lib/ctrl.v`, alongside the existing `MEM_*`, `PC_SRC_*` and `WREN`/`WDIS` macros. `MEM_TIMEOUT`'s default is also defined there.
- One sub-module: `mem_timeout_ctr`, with inputs clear, count-enable and limit, and output expired. It is instantiated once.

## Test plan
- **ADD, zero-wait memory:** `mem_ack` tied high, `mem_cmd`=NOP, `reg_wen`=WREN → states FETCH, DECODE, EXEC, WB; `rf_we` and `pc_we` each high for one cycle; `retired` goes 0→1 after 4 cycles.
- **LW with 3 wait cycles on the MEM access:** `mem_req` high for 4 cycles with `addr_sel`=1 and `mem_we`=0; `ir_we` pulses on the ack cycle; `rf_we`=1 in WB; instruction takes 8 cycles in total.
- **SW, then BEQ:** SW → `mem_we`=1 during MEM and `rf_we`=0 in WB. BEQ with `br_cond`=1 → `pc_sel`=`PC_SRC_BRCH`. Same BEQ with `br_cond`=0 → `pc_sel`=`PC_SRC_NEXT`.
- **Timeout:** `mem_ack` held low, `MEM_TIMEOUT`=15 → FAULT after 15 request cycles with `fault`=1 and `mem_req`=0. Repeat with ack on cycle 15 → completes normally, no fault.
- **Halt and reset:** `halt_req`=1 in DECODE → `halted`=1, no further `mem_req`, `retired` unchanged. Separately, `rst_n` low during a MEM wait → state FETCH, `retired`=0, `fault`=0 asynchronously.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: decoder field encodings, FSM states
// and the writeback PC-select helper.
package multicycle_ctrl_pkg;

    localparam int unsigned W_MEM_CMD         = 2;
    localparam int unsigned W_PC_SRC          = 2;
    localparam int unsigned MemTimeoutDefault = 15;

    typedef enum logic [W_MEM_CMD-1:0] {
        MemNop   = 2'd0,
        MemRead  = 2'd1,
        MemWrite = 2'd2
    } mem_cmd_e;

    typedef enum logic [W_PC_SRC-1:0] {
        PcSrcNext = 2'd0,
        PcSrcBrch = 2'd1,
        PcSrcJump = 2'd2
    } pc_src_e;

    localparam logic WREN = 1'b1;
    localparam logic WDIS = 1'b0;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StFault  = 3'd6
    } state_e;

    // An untaken branch falls through to the sequential PC.
    function automatic pc_src_e wb_pc_sel(input pc_src_e src, input logic br_taken);
        if (src == PcSrcBrch) begin
            return br_taken ? PcSrcBrch : PcSrcNext;
        end
        return src;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Decoder, datapath and memory-handshake signals shared between the sequencer
// (master) and the datapath/memory side (slave).
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    mem_cmd_e mem_cmd;
    logic     reg_wen;
    pc_src_e  pc_src;
    logic     br_cond;
    logic     halt_req;
    logic     mem_ack;

    logic     mem_req;
    logic     mem_we;
    logic     addr_sel;
    logic     ir_we;
    logic     alu_we;
    logic     rf_we;
    logic     pc_we;
    pc_src_e  pc_sel;

    modport master (
        input  mem_cmd, reg_wen, pc_src, br_cond, halt_req, mem_ack,
        output mem_req, mem_we, addr_sel, ir_we, alu_we, rf_we, pc_we, pc_sel
    );

    modport slave (
        output mem_cmd, reg_wen, pc_src, br_cond, halt_req, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_we, alu_we, rf_we, pc_we, pc_sel
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts un-acked memory request cycles; expired_o flags the cycle in which the
// count would reach the limit without an ack.
module mem_timeout_ctr #(
    parameter int unsigned CntW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [CntW-1:0] limit_i,
    output logic            expired_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != limit_i)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Extra bit keeps cnt+1 from wrapping when the limit is the maximum count value.
    assign expired_o = en_i && (({1'b0, cnt_q} + (CntW + 1)'(1)) >= {1'b0, limit_i});

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with one shared
// variable-latency memory port, sticky HALT and memory-timeout FAULT states.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
    parameter int unsigned W_RET       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus,
    output logic               halted_o,
    output logic               fault_o,
    output logic [W_RET-1:0]   retired_o
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q;
    logic             br_cond_q;
    logic [W_RET-1:0] retired_q;
    logic             halted_q;
    logic             fault_q;
    logic             expired;

    // Counter is held clear outside requests, so it restarts on every FETCH/MEM entry.
    mem_timeout_ctr #(
        .CntW (CntW)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!bus.mem_req),
        .en_i      (bus.mem_req && !bus.mem_ack),
        .limit_i   (CntW'(MEM_TIMEOUT)),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            br_cond_q <= 1'b0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (bus.mem_ack) begin
                        state_q <= StDecode;
                    end else if (expired) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end
                end
                StDecode: begin
                    if (bus.halt_req) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    br_cond_q <= bus.br_cond;
                    state_q   <= (bus.mem_cmd != MemNop) ? StMem : StWb;
                end
                StMem: begin
                    if (bus.mem_ack) begin
                        state_q <= StWb;
                    end else if (expired) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end
                end
                StWb: begin
                    retired_q <= retired_q + W_RET'(1);
                    state_q   <= StFetch;
                end
                StHalt, StFault: ;
                default: state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        bus.ir_we    = 1'b0;
        bus.alu_we   = 1'b0;
        bus.rf_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_sel   = PcSrcNext;
        unique case (state_q)
            StFetch: begin
                bus.mem_req = 1'b1;
                bus.ir_we   = bus.mem_ack;
            end
            StExec: begin
                bus.alu_we = 1'b1;
            end
            StMem: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (bus.mem_cmd == MemWrite);
                bus.ir_we    = bus.mem_ack && (bus.mem_cmd == MemRead);
            end
            StWb: begin
                bus.rf_we  = (bus.reg_wen == WREN) && (bus.mem_cmd != MemWrite);
                bus.pc_we  = 1'b1;
                bus.pc_sel = wb_pc_sel(bus.pc_src, br_cond_q);
            end
            default: ;
        endcase
    end

    assign halted_o  = halted_q;
    assign fault_o   = fault_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations are queued at
// issue and checked when the sequencer reaches writeback.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int unsigned MemTo = 15;
    localparam int unsigned WRet  = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            halted;
    logic            fault;
    logic [WRet-1:0] retired;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (MemTo),
        .W_RET       (WRet)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .halted_o  (halted),
        .fault_o   (fault),
        .retired_o (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    rf_we;
        pc_src_e pc_sel;
        int      cycles;
    } exp_t;

    exp_t            exp_q[$];
    int              total = 0;
    int              bad = 0;
    logic [WRet-1:0] exp_ret = '0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Leaves the bench just after a rising edge with the DUT in a fresh FETCH.
    task automatic do_reset();
        bus.mem_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ret = '0;
    endtask

    // fw/mw: wait cycles before ack on the fetch / data access.
    task automatic run_instr(input mem_cmd_e cmd, input logic wen, input pc_src_e src,
                             input logic br, input int fw, input int mw);
        exp_t e;
        exp_t got_e;
        int   cyc = 0;
        int   nreq = 0;
        int   mem_n = 0;
        int   fetch_n = 0;
        int   ir_n = 0;
        int   rf_n = 0;
        int   pc_n = 0;
        logic done = 1'b0;
        logic prev_ack = 1'b0;

        e.rf_we  = (wen == WREN) && (cmd != MemWrite);
        e.pc_sel = (src == PcSrcBrch) ? (br ? PcSrcBrch : PcSrcNext) : src;
        e.cycles = 4 + fw + ((cmd != MemNop) ? 1 + mw : 0);
        exp_q.push_back(e);
        exp_ret = exp_ret + 1'b1;

        bus.mem_cmd  = cmd;
        bus.reg_wen  = wen;
        bus.pc_src   = src;
        bus.halt_req = 1'b0;

        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (prev_ack) check_eq("req_low_after_ack", bus.mem_req, 0);
            bus.br_cond = bus.alu_we ? br : !br;
            if (bus.mem_req) begin
                nreq++;
                bus.mem_ack = (nreq > (bus.addr_sel ? mw : fw));
                if (bus.addr_sel) begin
                    mem_n++;
                    check_eq("mem_we", bus.mem_we, (cmd == MemWrite));
                end else begin
                    fetch_n++;
                end
            end else begin
                nreq = 0;
                bus.mem_ack = 1'b1;  // stray ack, must be ignored
            end
            #1;
            ir_n += int'(bus.ir_we);
            rf_n += int'(bus.rf_we);
            pc_n += int'(bus.pc_we);
            prev_ack = bus.mem_req && bus.mem_ack;
            if (bus.pc_we) begin
                done = 1'b1;
                if (exp_q.size() > 0) begin
                    got_e = exp_q.pop_front();
                    check_eq("wb_rf_we", bus.rf_we, got_e.rf_we);
                    check_eq("wb_pc_sel", bus.pc_sel, got_e.pc_sel);
                    check_eq("instr_cycles", cyc, got_e.cycles);
                end
            end
        end
        check_eq("wb_reached", done, 1);
        check_eq("fetch_req_cycles", fetch_n, fw + 1);
        check_eq("mem_req_cycles", mem_n, (cmd != MemNop) ? mw + 1 : 0);
        check_eq("ir_we_pulses", ir_n, (cmd == MemRead) ? 2 : 1);
        check_eq("rf_we_pulses", rf_n, e.rf_we);
        check_eq("pc_we_pulses", pc_n, 1);
        @(posedge clk);
        #1;
        check_eq("retired", retired, exp_ret);
        check_eq("no_fault", fault, 0);
    endtask

    initial begin
        int n;
        mem_cmd_e rc;
        pc_src_e  rs;

        bus.mem_cmd  = MemNop;
        bus.reg_wen  = WDIS;
        bus.pc_src   = PcSrcNext;
        bus.br_cond  = 1'b0;
        bus.halt_req = 1'b0;
        bus.mem_ack  = 1'b0;
        #3;
        check_eq("rst_mem_req", bus.mem_req, 1);
        check_eq("rst_addr_sel", bus.addr_sel, 0);
        check_eq("rst_pc_we", bus.pc_we, 0);
        check_eq("rst_retired", retired, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_fault", fault, 0);
        do_reset();

        run_instr(MemNop,   WREN, PcSrcNext, 1'b0, 0, 0);  // ADD
        run_instr(MemRead,  WREN, PcSrcNext, 1'b0, 0, 3);  // LW, 3 waits
        run_instr(MemWrite, WREN, PcSrcNext, 1'b0, 0, 0);  // SW
        run_instr(MemWrite, WDIS, PcSrcNext, 1'b1, 1, 2);
        run_instr(MemNop,   WDIS, PcSrcBrch, 1'b1, 0, 0);  // BEQ taken
        run_instr(MemNop,   WDIS, PcSrcBrch, 1'b0, 0, 0);  // BEQ not taken
        run_instr(MemNop,   WDIS, PcSrcJump, 1'b0, 2, 0);
        for (int i = 0; i < 8; i++) begin
            rc = mem_cmd_e'($urandom_range(2, 0));
            rs = pc_src_e'($urandom_range(2, 0));
            run_instr(rc, 1'($urandom_range(1, 0)), rs, 1'($urandom_range(1, 0)),
                      int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
        end
        run_instr(MemRead, WREN, PcSrcNext, 1'b0, 14, 14);  // ack on the limit cycle

        // Reset during a MEM wait.
        bus.mem_cmd = MemRead;
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            @(negedge clk);
            if (bus.mem_req && bus.addr_sel) begin
                n++;
                bus.mem_ack = 1'b0;
            end else begin
                bus.mem_ack = bus.mem_req;
            end
        end
        check_eq("mid_mem_reached", n, 5);
        check_eq("retired_before_rst", retired, exp_ret);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_mem_req", bus.mem_req, 1);
        check_eq("arst_addr_sel", bus.addr_sel, 0);
        check_eq("arst_retired", retired, 0);
        check_eq("arst_fault", fault, 0);
        exp_ret = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr(MemNop, WREN, PcSrcNext, 1'b0, 0, 0);

        // Halt in DECODE, with stray acks held high afterwards.
        bus.mem_cmd  = MemNop;
        bus.halt_req = 1'b1;
        @(negedge clk);
        check_eq("halt_fetch_req", bus.mem_req, 1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("halt_mem_req", bus.mem_req, 0);
            check_eq("halt_pc_we", bus.pc_we, 0);
            check_eq("halted", halted, 1);
            check_eq("halt_retired", retired, exp_ret);
        end
        bus.halt_req = 1'b0;

        // Fetch that never gets acked.
        do_reset();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.mem_req) break;
            n++;
        end
        check_eq("to_req_cycles", n, MemTo);
        check_eq("to_fault", fault, 1);
        check_eq("to_halted", halted, 0);
        bus.mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("to_fault_sticky", fault, 1);
        check_eq("to_req_stays_low", bus.mem_req, 0);

        do_reset();
        check_eq("fault_cleared", fault, 0);
        run_instr(MemNop, WREN, PcSrcNext, 1'b0, 14, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
